y86_imem_port: RTL

Instruction-memory responder for the Y86-64 fetch stage. It is the memory side of the `PC` -> 10-byte `Byte` fetch interface consumed by `y86wrap`.
- A program image is first streamed in byte-serially through a valid/ready load port.
- The block then answers fetch requests with a registered 80-bit instruction window and an `imem_err` flag.
- It replaces hard-coded memory initialisation in benches and lets the same program image be reloaded after reset.

---
 rtl/y86_imem_port.sv | 119 +++++++++++
 1 files changed

// File: rtl/y86_imem_port.sv
// Y86-64 instruction memory responder: byte-serial image load, then 1-cycle
// registered 10-byte fetch windows with range error and zero padding past the image.
module y86_imem_port #(
    parameter int MEM_BYTES = 1024,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [7:0]       ld_byte,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             ld_overflow,
    output logic [LEN_W-1:0] prog_len,
    output logic             loaded,
    input  logic             fetch_req,
    input  logic [63:0]      PC,
    output logic             fetch_valid,
    output logic [79:0]      Byte,
    output logic             imem_err
);

    localparam int               AW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [LEN_W-1:0] MEM_LEN = LEN_W'(MEM_BYTES);
    localparam logic [63:0]      LAST_PC = 64'(MEM_BYTES - 10);

    typedef enum logic {S_LOAD, S_RUN} state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [MEM_BYTES];
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             loaded_q, loaded_d;
    logic             fv_q, fv_d;
    logic [79:0]      byte_q, byte_d;
    logic             err_q, err_d;
    logic             wr_en;
    logic             range_err;
    logic [79:0]      win;

    // Full 64-bit compare so addresses near 2^64 cannot wrap into range.
    assign range_err = (PC > LAST_PC);

    // Bytes at or past prog_len read as halt (00), hiding stale memory.
    for (genvar k = 0; k < 10; k++) begin : g_win
        logic [63:0] addr;
        assign addr         = PC + 64'(k);
        assign win[8*k +: 8] = (addr < 64'(len_q)) ? mem_q[addr[AW-1:0]] : 8'h00;
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        loaded_d = loaded_q;
        fv_d     = 1'b0;
        byte_d   = byte_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (ld_valid) begin
                    if (len_q < MEM_LEN) begin
                        wr_en = 1'b1;
                        len_d = len_q + LEN_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d  = S_RUN;
                        loaded_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (fetch_req) begin
                    fv_d   = 1'b1;
                    err_d  = range_err;
                    byte_d = range_err ? 80'h0 : win;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOAD;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            loaded_q <= 1'b0;
            fv_q     <= 1'b0;
            byte_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            loaded_q <= loaded_d;
            fv_q     <= fv_d;
            byte_q   <= byte_d;
            err_q    <= err_d;
        end
    end

    // Array deliberately not reset so a reload only rewrites what it needs.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[len_q[AW-1:0]] <= ld_byte;
    end

    assign ld_ready    = (state_q == S_LOAD);
    assign ld_overflow = ovf_q;
    assign prog_len    = len_q;
    assign loaded      = loaded_q;
    assign fetch_valid = fv_q;
    assign Byte        = byte_q;
    assign imem_err    = err_q;

endmodule
